branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Branch sequencing controller for the pipelined RV32I core.
- Predicts at decode using a table of 2-bit saturating counters (BHT). Takes the execute-stage branch outcome from the branch-condition unit, detects mispredictions, issues a one-cycle PC redirect and holds front-end flush for a fixed number of cycles.
- Sits between decode, the branch-condition unit in execute, and the PC/pipeline-register control.
- Also maintains branch and misprediction performance counters.

Parameters:
- IDX_BITS, 6, BHT index width; table depth is 2^IDX_BITS entries.
- FLUSH_CYCLES, 2, number of cycles flush_if_id/flush_id_ex stay asserted after a mispredict; legal range 1..15.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_is_branch  in  1  decode-stage instruction is a conditional branch.
- id_pc  in  32  decode-stage PC.
- pred_taken  out  1  prediction for the decode-stage branch (combinational).
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_is_branch  in  1  execute-stage instruction is a conditional branch.
- ex_pc  in  32  execute-stage PC.
- ex_pred_taken  in  1  prediction carried down the pipe with the branch.
- ex_taken  in  1  actual outcome from the branch-condition unit.
- ex_target  in  32  computed branch target.
- redirect  out  1  one-cycle pulse: load PC with redirect_pc.
- redirect_pc  out  32  corrected fetch address.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- busy  out  1  high while in FLUSH state.
- br_count  out  CNT_W  resolved branches since reset.
- mp_count  out  CNT_W  mispredictions since reset.

Behaviour:
- Reset: all outputs 0; state IDLE; flush counter 0; every BHT entry set to 2'b01 (weakly not-taken).
- BHT index is id_pc[IDX_BITS+1:2] for reads and ex_pc[IDX_BITS+1:2] for updates.
- pred_taken = id_is_branch & BHT[idx][1]. Purely combinational, no registering.
- A read and a write to the same index in the same cycle return the old value; no bypass.
- A resolve event is ex_valid & ex_is_branch, sampled at the edge while state is IDLE.
- On a resolve event:
  - BHT entry increments if ex_taken, saturating at 3; otherwise it decrements, saturating at 0.
  - br_count increments (wraps modulo 2^CNT_W).
- A mispredict is a resolve event with ex_taken != ex_pred_taken. It additionally does the following, all registered so they are visible the cycle after detection (cycle T+1):
  - mp_count increments (wraps).
  - redirect = 1 for exactly one cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4 (modulo 2^32).
  - flush_if_id = flush_id_ex = 1 for exactly FLUSH_CYCLES cycles, T+1 .. T+FLUSH_CYCLES.
  - busy has the same timing as flush.
  - State moves to FLUSH.
- redirect_pc holds its value after the redirect pulse until the next mispredict.
- FLUSH state:
  - A counter loads FLUSH_CYCLES-1 on entry and decrements each cycle.
  - Return to IDLE occurs when the counter is 0, so flush drops on cycle T+FLUSH_CYCLES+1.
  - All ex_* inputs are ignored (wrong-path instructions): no BHT update, no counter change, no new redirect.
- A correctly predicted branch updates the BHT and br_count only. No redirect, no flush, state stays IDLE.
- ex_valid=0 or ex_is_branch=0: no effect.
- A back-to-back mispredict is possible on the first IDLE cycle after FLUSH and follows the same timing.
- Reset asserted mid-FLUSH: returns to IDLE immediately with outputs 0 and the BHT reinitialised; no residual redirect or flush.

Test Plan:
- Reset then id_is_branch=1, id_pc=0x100 -> pred_taken=0; all outputs 0; br_count=mp_count=0.
- Resolve at T with ex_pc=0x100, ex_pred_taken=0, ex_taken=1, ex_target=0x200 (FLUSH_CYCLES=2) -> redirect=1 only at T+1; redirect_pc=0x200; flush_if_id/flush_id_ex/busy high at T+1 and T+2, low at T+3; mp_count=1; afterwards pred_taken for id_pc=0x100 is 1.
- Mispredict taken-predicted/not-taken, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
- Three correctly predicted taken resolves at ex_pc=0x40 -> no redirect or flush; counter saturates at 3; one not-taken resolve (mispredict) -> counter 2, pred_taken still 1; br_count=4, mp_count=1.
- Mispredict, then a second mispredicting branch presented during FLUSH -> ignored (no second redirect; br_count/mp_count unchanged); a mispredict on the first IDLE cycle after FLUSH -> redirect on the following cycle.
- rst asserted asynchronously mid-FLUSH -> flush/busy/redirect drop to 0 without waiting for a clock; state IDLE; the BHT entry for 0x100 reads pred_taken=0 again.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-time 2-bit BHT predictor with execute-stage resolve,
// one-cycle mispredict redirect, fixed-length front-end flush and perf counters.
`default_nettype none

module branch_ctrl #(
  parameter int IDX_BITS     = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_is_branch,
  input  logic [31:0]      id_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          flush_cnt, flush_cnt_nxt;
  logic [1:0]          bht [DEPTH];
  logic [IDX_BITS-1:0] rd_idx, wr_idx;
  logic                resolve, mispredict;
  logic                unused_id_pc_bits;

  assign rd_idx            = id_pc[IDX_BITS+1:2];
  assign wr_idx            = ex_pc[IDX_BITS+1:2];
  assign unused_id_pc_bits = ^{id_pc[31:IDX_BITS+2], id_pc[1:0]};

  // Reads see the pre-update entry; same-index writes land at the edge.
  assign pred_taken = id_is_branch & bht[rd_idx][1];

  // Execute-stage inputs are wrong-path while flushing, so only IDLE resolves.
  assign resolve    = (state == IDLE) & ex_valid & ex_is_branch;
  assign mispredict = resolve & (ex_taken != ex_pred_taken);

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) state_nxt = IDLE;
        else                   flush_cnt_nxt = flush_cnt - 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      if (ex_taken) begin
        if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
      end else begin
        if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      redirect <= mispredict;
      if (resolve) br_count <= br_count + 1'b1;
      if (mispredict) begin
        mp_count    <= mp_count + 1'b1;
        redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
      end
    end
  end

  assign busy        = (state == FLUSH);
  assign flush_if_id = busy;
  assign flush_id_ex = busy;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed stimulus for branch_ctrl, checked every cycle against
// a cycle-budget reference model plus hand-computed literal expectations.
`default_nettype none

module tb_branch_ctrl;

  localparam int IDX_BITS     = 6;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             id_is_branch = 1'b0;
  logic [31:0]      id_pc = 32'd0;
  logic             pred_taken;
  logic             ex_valid = 1'b0;
  logic             ex_is_branch = 1'b0;
  logic [31:0]      ex_pc = 32'd0;
  logic             ex_pred_taken = 1'b0;
  logic             ex_taken = 1'b0;
  logic [31:0]      ex_target = 32'd0;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_if_id, flush_id_ex, busy;
  logic [CNT_W-1:0] br_count, mp_count;

  int checks   = 0;
  int failures = 0;

  branch_ctrl #(.IDX_BITS(IDX_BITS), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_is_branch(id_is_branch), .id_pc(id_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy(busy),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  // Reference model: counters as small integers, flush as "cycles remaining".
  int               m_bht [1 << IDX_BITS];
  logic [CNT_W-1:0] m_br, m_mp;
  int               m_rem;
  logic             m_redirect;
  logic [31:0]      m_rpc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1 << IDX_BITS); i++) m_bht[i] <= 1;
      m_br <= '0; m_mp <= '0; m_rem <= 0; m_redirect <= 1'b0; m_rpc <= 32'd0;
    end else begin
      m_redirect <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end else if (ex_valid && ex_is_branch) begin
        m_br <= m_br + 1'b1;
        if (ex_taken) m_bht[ex_pc[IDX_BITS+1:2]] <= (m_bht[ex_pc[IDX_BITS+1:2]] >= 3) ? 3 : m_bht[ex_pc[IDX_BITS+1:2]] + 1;
        else          m_bht[ex_pc[IDX_BITS+1:2]] <= (m_bht[ex_pc[IDX_BITS+1:2]] <= 0) ? 0 : m_bht[ex_pc[IDX_BITS+1:2]] - 1;
        if (ex_taken != ex_pred_taken) begin
          m_mp       <= m_mp + 1'b1;
          m_redirect <= 1'b1;
          m_rpc      <= ex_taken ? ex_target : ex_pc + 32'd4;
          m_rem      <= FLUSH_CYCLES;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_pred;
    exp_pred = id_is_branch && (m_bht[id_pc[IDX_BITS+1:2]] >= 2);
    check("m_pred_taken", 32'(pred_taken), 32'(exp_pred));
    check("m_redirect", 32'(redirect), 32'(m_redirect));
    check("m_redirect_pc", redirect_pc, m_rpc);
    check("m_flush_if_id", 32'(flush_if_id), 32'(m_rem > 0));
    check("m_flush_id_ex", 32'(flush_id_ex), 32'(m_rem > 0));
    check("m_busy", 32'(busy), 32'(m_rem > 0));
    check("m_br_count", 32'(br_count), 32'(m_br));
    check("m_mp_count", 32'(mp_count), 32'(m_mp));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic pred, input logic tk, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc;
    ex_pred_taken = pred; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'd0;
    ex_pred_taken = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();

    // Reset state and initial weakly-not-taken prediction.
    id_is_branch = 1'b1; id_pc = 32'h100;
    #1;
    check("reset_pred_taken", 32'(pred_taken), 32'd0);
    check("reset_redirect", 32'(redirect), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_br_count", 32'(br_count), 32'd0);
    check("reset_mp_count", 32'(mp_count), 32'd0);

    // Not-taken predicted, actually taken.
    drive_ex(32'h100, 1'b0, 1'b1, 32'h200);
    tick(); clear_ex();
    check("mp1_redirect_t1", 32'(redirect), 32'd1);
    check("mp1_redirect_pc", redirect_pc, 32'h200);
    check("mp1_flush_t1", 32'({flush_if_id, flush_id_ex, busy}), 32'h7);
    tick();
    check("mp1_redirect_t2", 32'(redirect), 32'd0);
    check("mp1_flush_t2", 32'({flush_if_id, flush_id_ex, busy}), 32'h7);
    tick();
    check("mp1_flush_t3", 32'({flush_if_id, flush_id_ex, busy}), 32'h0);
    check("mp1_mp_count", 32'(mp_count), 32'd1);
    check("mp1_pred_after", 32'(pred_taken), 32'd1);

    // Not-taken fall-through address wraps at the top of memory.
    drive_ex(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
    tick(); clear_ex();
    check("wrap_redirect", 32'(redirect), 32'd1);
    check("wrap_redirect_pc", redirect_pc, 32'h0000_0000);
    tick(); tick();
    check("wrap_pc_held", redirect_pc, 32'h0000_0000);

    // Saturation at 3 on a taken streak, then one not-taken mispredict.
    do_reset();
    id_is_branch = 1'b1; id_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      drive_ex(32'h40, 1'b1, 1'b1, 32'h80);
      tick();
      check("sat_no_redirect", 32'(redirect), 32'd0);
    end
    drive_ex(32'h40, 1'b1, 1'b0, 32'h80);
    tick(); clear_ex();
    check("sat_mp_redirect_pc", redirect_pc, 32'h44);
    check("sat_pred_still_taken", 32'(pred_taken), 32'd1);
    check("sat_br_count", 32'(br_count), 32'd4);
    check("sat_mp_count", 32'(mp_count), 32'd1);
    tick(); tick();

    // Mispredicts presented during FLUSH are wrong-path; first IDLE cycle is live.
    drive_ex(32'h80, 1'b0, 1'b1, 32'h300);
    tick();
    drive_ex(32'h84, 1'b0, 1'b1, 32'h400);
    check("bb_redirect_pc_1", redirect_pc, 32'h300);
    tick();
    check("bb_ignored_redirect", 32'(redirect), 32'd0);
    check("bb_ignored_br", 32'(br_count), 32'd5);
    check("bb_ignored_mp", 32'(mp_count), 32'd2);
    tick();
    check("bb_idle_busy", 32'(busy), 32'd0);
    drive_ex(32'h88, 1'b1, 1'b0, 32'h500);
    tick(); clear_ex();
    check("bb_second_redirect", 32'(redirect), 32'd1);
    check("bb_second_pc", redirect_pc, 32'h8C);
    check("bb_second_br", 32'(br_count), 32'd6);
    check("bb_second_mp", 32'(mp_count), 32'd3);
    tick(); tick();

    // Asynchronous reset in the middle of a flush.
    id_is_branch = 1'b1; id_pc = 32'h100;
    drive_ex(32'h100, 1'b0, 1'b1, 32'h600);
    tick(); clear_ex();
    check("arst_pre_busy", 32'(busy), 32'd1);
    check("arst_pre_pred", 32'(pred_taken), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_flush", 32'({flush_if_id, flush_id_ex, busy}), 32'h0);
    check("arst_redirect", 32'(redirect), 32'd0);
    check("arst_pred_taken", 32'(pred_taken), 32'd0);
    check("arst_counts", 32'({br_count, mp_count}), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    check("arst_after_busy", 32'(busy), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
